id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_pkg.sv | 46 ++++
 rtl/id_regfile.sv | 42 ++++
 rtl/id_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// id_pkg -- shared definitions for the instruction decode stage.
//
// Contents:
//   OP_ADD / OP_SUB   : R-type opcodes (rd <- rs op rt)
//   OP_ADDI / OP_SUBI : I-type opcodes (rd <- rs op sext(imm))
//   *_LSB, FIELD_W    : bit positions of the instruction fields
//   id_dec_t          : control bundle extracted from one instruction
//   decodeInstr()     : splits an instruction into an id_dec_t
package id_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;

  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;

  // The rt field doubles as the immediate for I-type instructions.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       legal;
    logic       itype;
    logic       we;
  } id_dec_t;

  // Pure field extraction and opcode classification; no operand values here.
  function automatic id_dec_t decodeInstr(input logic [15:0] instr);
    id_dec_t d;
    d.opcode = instr[OPC_LSB +: FIELD_W];
    d.rd     = instr[RD_LSB  +: FIELD_W];
    d.rs     = instr[RS_LSB  +: FIELD_W];
    d.rt     = instr[RT_LSB  +: FIELD_W];
    d.itype  = (d.opcode == OP_ADDI) || (d.opcode == OP_SUBI);
    d.legal  = d.itype || (d.opcode == OP_ADD) || (d.opcode == OP_SUB);
    d.we     = d.legal && (d.rd != 4'd0);
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile -- 16-entry register file, two combinational read ports, one
// synchronous write port. Register 0 is hardwired to zero.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset (clears all)
//   we_i, waddr_i,
//   wdata_i            : write strobe, index and data (commit on posedge)
//   raddrA_i, rdataA_o : read port A
//   raddrB_i, rdataB_o : read port B
module id_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddrA_i,
  input  logic [3:0]        raddrB_i,
  output logic [DATA_W-1:0] rdataA_o,
  output logic [DATA_W-1:0] rdataB_o
);

  logic [DATA_W-1:0] mem_q [16];

  // Storage update: reset clears every entry, writes to r0 are dropped so it
  // stays zero even though the read mux below also forces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 4'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads return the pre-write contents during a write cycle.
  assign rdataA_o = (raddrA_i == 4'd0) ? '0 : mem_q[raddrA_i];
  assign rdataB_o = (raddrB_i == 4'd0) ? '0 : mem_q[raddrB_i];

endmodule

// File: rtl/id_stage.sv
// id_stage -- instruction decode stage with a single output register and a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_instr  : instruction from fetch
//   wb_en/wb_addr/wb_data       : register writeback port
//   out_valid/out_ready         : handshake to the ALU
//   out_opcode, out_a, out_b,
//   out_imm, out_rd, out_we,
//   out_illegal                 : decoded operand bundle
//
// Build option: define ID_BYPASS_EN to forward a same-cycle writeback into
// the captured operands; otherwise the write is visible from the next cycle.
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [3:0]        out_rd,
  output logic              out_we,
  output logic              out_illegal
);

  id_dec_t           dec;
  logic [DATA_W-1:0] rfA, rfB, rsVal, rtVal, immExt;
  logic              capture;

  logic              outValid_q, outValid_d;
  logic [3:0]        outOpcode_q, outOpcode_d;
  logic [DATA_W-1:0] outA_q, outA_d;
  logic [DATA_W-1:0] outB_q, outB_d;
  logic [DATA_W-1:0] outImm_q, outImm_d;
  logic [3:0]        outRd_q, outRd_d;
  logic              outWe_q, outWe_d;
  logic              outIllegal_q, outIllegal_d;

  assign dec = decodeInstr(in_instr);

  id_regfile #(.DATA_W(DATA_W)) uRegfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddrA_i (dec.rs),
    .raddrB_i (dec.rt),
    .rdataA_o (rfA),
    .rdataB_o (rfB)
  );

`ifdef ID_BYPASS_EN
  // Forward a writeback landing this very cycle so the capture sees it.
  assign rsVal = (wb_en && (wb_addr == dec.rs) && (wb_addr != 4'd0)) ? wb_data : rfA;
  assign rtVal = (wb_en && (wb_addr == dec.rt) && (wb_addr != 4'd0)) ? wb_data : rfB;
`else
  assign rsVal = rfA;
  assign rtVal = rfB;
`endif

  assign immExt = {{(DATA_W-IMM_W){dec.rt[IMM_W-1]}}, dec.rt[IMM_W-1:0]};

  // Single register, no skid: accept whenever the slot is empty or drains now.
  assign in_ready = !outValid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // Next-state: a capture replaces the whole bundle (operands read now, so a
  // later writeback cannot disturb held values); a drain alone only drops valid.
  always_comb begin
    outValid_d   = outValid_q;
    outOpcode_d  = outOpcode_q;
    outA_d       = outA_q;
    outB_d       = outB_q;
    outImm_d     = outImm_q;
    outRd_d      = outRd_q;
    outWe_d      = outWe_q;
    outIllegal_d = outIllegal_q;
    if (capture) begin
      outValid_d   = 1'b1;
      outOpcode_d  = dec.opcode;
      outRd_d      = dec.rd;
      outWe_d      = dec.we;
      outIllegal_d = !dec.legal;
      outA_d       = dec.legal ? rsVal : '0;
      outB_d       = (dec.legal && !dec.itype) ? rtVal : '0;
      outImm_d     = (dec.legal && dec.itype) ? immExt : '0;
    end else if (out_ready) begin
      outValid_d   = 1'b0;
    end
  end

  // Output register; reset discards any held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      outOpcode_q  <= '0;
      outA_q       <= '0;
      outB_q       <= '0;
      outImm_q     <= '0;
      outRd_q      <= '0;
      outWe_q      <= 1'b0;
      outIllegal_q <= 1'b0;
    end else begin
      outValid_q   <= outValid_d;
      outOpcode_q  <= outOpcode_d;
      outA_q       <= outA_d;
      outB_q       <= outB_d;
      outImm_q     <= outImm_d;
      outRd_q      <= outRd_d;
      outWe_q      <= outWe_d;
      outIllegal_q <= outIllegal_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_opcode  = outOpcode_q;
  assign out_a       = outA_q;
  assign out_b       = outB_q;
  assign out_imm     = outImm_q;
  assign out_rd      = outRd_q;
  assign out_we      = outWe_q;
  assign out_illegal = outIllegal_q;

endmodule
